// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Purpose : groups the three result-source handshakes (ALU, LSU, MDU), the
//           issue-side destination notification, the register-file write
//           port and the pending-write scoreboard into one interface.
// Modports: slave  - the arbiter view (valids/rd/data/issue in; readys,
//                    write port and busy_mask out).
//           master - the producer / register-file view (the opposite).
interface wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;

  logic            iss_valid;
  logic [4:0]      iss_rd;

  logic [31:0]     busy_mask;
  logic            wen;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  iss_valid, iss_rd,
    output alu_ready, lsu_ready, mdu_ready,
    output busy_mask, wen, waddr, wdata
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output iss_valid, iss_rd,
    input  alu_ready, lsu_ready, mdu_ready,
    input  busy_mask, wen, waddr, wdata
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter.
// Purpose : picks at most one of ALU / LSU / MDU results per cycle and writes
//           it to the register file one cycle later. The ALU has priority; the
//           LSU and MDU share the remaining slot round-robin. A starvation
//           counter lets a waiting LSU/MDU result preempt the ALU after
//           STARVE_LIM denied cycles. A 32-bit scoreboard tracks registers
//           with an outstanding write.
// Ports   : clk  - sole clock (posedge)
//           rst  - synchronous, active-high reset
//           bus  - wb_arbiter_if.slave (handshakes, issue notify, write port,
//                  busy_mask)
module wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic {
    PTR_LSU = 1'b0,
    PTR_MDU = 1'b1
  } rr_ptr_e;

  rr_ptr_e         ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            starve_s;
  logic            alu_ready_s, lsu_ready_s, mdu_ready_s;
  logic            alu_acc_s, lsu_acc_s, mdu_acc_s;
  logic            low_acc_s;
  logic            acc_any_s;
  logic [4:0]      acc_rd_s;
  logic [XLEN-1:0] acc_data_s;

  // Grant logic: ready is a function of valids, pointer, counter and rst only.
  always_comb begin
    starve_s    = (cnt_q == CW'(STARVE_LIM));
    alu_ready_s = ~rst & ~starve_s;
    alu_acc_s   = bus.alu_valid & alu_ready_s;
    // A sole valid low-priority source wins regardless of the pointer.
    lsu_ready_s = ~rst & ~alu_acc_s & bus.lsu_valid &
                  (~bus.mdu_valid | (ptr_q == PTR_LSU));
    mdu_ready_s = ~rst & ~alu_acc_s & bus.mdu_valid &
                  (~bus.lsu_valid | (ptr_q == PTR_MDU));
    lsu_acc_s   = bus.lsu_valid & lsu_ready_s;
    mdu_acc_s   = bus.mdu_valid & mdu_ready_s;
    low_acc_s   = lsu_acc_s | mdu_acc_s;
  end

  // Result mux for the single accepted source.
  always_comb begin
    acc_any_s  = 1'b0;
    acc_rd_s   = 5'd0;
    acc_data_s = '0;
    if (alu_acc_s) begin
      acc_any_s  = 1'b1;
      acc_rd_s   = bus.alu_rd;
      acc_data_s = bus.alu_data;
    end else if (lsu_acc_s) begin
      acc_any_s  = 1'b1;
      acc_rd_s   = bus.lsu_rd;
      acc_data_s = bus.lsu_data;
    end else if (mdu_acc_s) begin
      acc_any_s  = 1'b1;
      acc_rd_s   = bus.mdu_rd;
      acc_data_s = bus.mdu_data;
    end else begin
      acc_any_s  = 1'b0;
    end
  end

  // Next-state for pointer, starvation counter, write port and scoreboard.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;

    if (low_acc_s) begin
      ptr_d = (ptr_q == PTR_LSU) ? PTR_MDU : PTR_LSU;
    end else begin
      ptr_d = ptr_q;
    end

    if (low_acc_s || !(bus.lsu_valid || bus.mdu_valid)) begin
      cnt_d = '0;
    end else if (!starve_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // rd = 0 still completes the handshake but never writes.
    if (acc_any_s) begin
      wen_d   = (acc_rd_s != 5'd0);
      waddr_d = acc_rd_s;
      wdata_d = acc_data_s;
    end else begin
      wen_d   = 1'b0;
    end

    // Clear first so a same-cycle reissue of that register wins.
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= PTR_LSU;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
      busy_q  <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.alu_ready = alu_ready_s;
  assign bus.lsu_ready = lsu_ready_s;
  assign bus.mdu_ready = mdu_ready_s;
  assign bus.wen       = wen_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.busy_mask = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter (XLEN = 64, STARVE_LIM = 4).
// Inputs change on the falling edge; checks are taken 1 time unit later, so
// readys reflect this cycle's inputs and registered outputs reflect the
// previous rising edge.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  wb_arbiter_if #(.XLEN(64)) bus ();

  wb_arbiter #(.XLEN(64), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;  logic [4:0] ard; logic [63:0] ad;
    logic        lv;  logic [4:0] lrd; logic [63:0] ld;
    logic        mv;  logic [4:0] mrd; logic [63:0] md;
    logic        iv;  logic [4:0] ird;
    logic [2:0]  e_rdy;   // {alu, lsu, mdu}
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(
    input logic r,
    input logic av, input logic [4:0] ard, input logic [63:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
    input logic mv, input logic [4:0] mrd, input logic [63:0] md,
    input logic iv, input logic [4:0] ird,
    input logic [2:0] e_rdy, input logic e_wen, input logic [4:0] e_waddr,
    input logic [63:0] e_wdata, input logic [31:0] e_busy);
    vec_t v;
    v.rst = r;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_waddr = e_waddr;
    v.e_wdata = e_wdata; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_in(
    input logic r,
    input logic av, input logic [4:0] ard, input logic [63:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
    input logic mv, input logic [4:0] mrd, input logic [63:0] md,
    input logic iv, input logic [4:0] ird);
    @(negedge clk);
    rst = r;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
    bus.mdu_valid = mv; bus.mdu_rd = mrd; bus.mdu_data = md;
    bus.iss_valid = iv; bus.iss_rd = ird;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_wen, input logic [4:0] e_waddr,
                         input logic [63:0] e_wdata, input logic [31:0] e_busy);
    chk({tag, ".wen"},   {63'd0, bus.wen},   {63'd0, e_wen});
    chk({tag, ".waddr"}, {59'd0, bus.waddr}, {59'd0, e_waddr});
    chk({tag, ".wdata"}, bus.wdata,          e_wdata);
    chk({tag, ".busy"},  {32'd0, bus.busy_mask}, {32'd0, e_busy});
  endtask

  task automatic chk_rdy(input string tag, input logic [2:0] e_rdy);
    chk({tag, ".rdy"}, {61'd0, bus.alu_ready, bus.lsu_ready, bus.mdu_ready}, {61'd0, e_rdy});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 64'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 64'd0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = 5'd0; bus.mdu_data = 64'd0;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;

    //             rst  alu                 lsu                mdu                iss      rdy     wen waddr wdata       busy
    vecs[0] = mk(1'b1, 1'b1, 5'd5, 64'hDEAD, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 64'h0,    32'h0);
    vecs[1] = mk(1'b0, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 3'b100, 1'b0, 5'd0, 64'h0,    32'h0);
    vecs[2] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 3'b110, 1'b1, 5'd5, 64'hDEAD, 32'h80);
    vecs[3] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b1, 5'd3, 64'h34, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 3'b101, 1'b1, 5'd3, 64'h33,   32'h80);
    vecs[4] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 3'b100, 1'b1, 5'd7, 64'h77,   32'h80);
    vecs[5] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 3'b100, 1'b0, 5'd7, 64'h77,   32'h80);
    vecs[6] = mk(1'b0, 1'b1, 5'd0, 64'h1,    1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 3'b100, 1'b0, 5'd7, 64'h77,   32'h80);
    vecs[7] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 3'b101, 1'b0, 5'd0, 64'h1,    32'h80);
    vecs[8] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 3'b110, 1'b1, 5'd9, 64'h99,   32'h80);
    vecs[9] = mk(1'b0, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 3'b100, 1'b1, 5'd4, 64'h44,   32'h80);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].ad,
             vecs[i].lv, vecs[i].lrd, vecs[i].ld,
             vecs[i].mv, vecs[i].mrd, vecs[i].md,
             vecs[i].iv, vecs[i].ird);
      chk_rdy($sformatf("vec%0d", i), vecs[i].e_rdy);
      chk_out($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_waddr,
              vecs[i].e_wdata, vecs[i].e_busy);
    end

    // Starvation: ALU and LSU both valid; LSU denied 4 cycles, wins the 5th.
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b0, 1'b1, 5'd12, 64'h100 + 64'(k), 1'b1, 5'd2, 64'h22,
             1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
      chk_rdy($sformatf("starve%0d", k), (k < 5) ? 3'b100 : 3'b010);
      if (k >= 2)
        chk_out($sformatf("starve%0d", k), 1'b1, 5'd12, 64'h100 + 64'(k - 1), 32'h80);
    end
    // Counter back at zero: ALU regains priority.
    set_in(1'b0, 1'b1, 5'd12, 64'h106, 1'b1, 5'd2, 64'h22,
           1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    chk_rdy("starve6", 3'b100);
    chk_out("starve6", 1'b1, 5'd2, 64'h22, 32'h80);

    // Reset in an accept cycle (pointer currently favours MDU).
    set_in(1'b1, 1'b1, 5'd6, 64'h66, 1'b1, 5'd3, 64'h33,
           1'b1, 5'd9, 64'h99, 1'b1, 5'd8);
    chk_rdy("rstacc", 3'b000);
    set_in(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h33,
           1'b1, 5'd9, 64'h99, 1'b0, 5'd0);
    chk_out("postrst", 1'b0, 5'd0, 64'h0, 32'h0);
    chk_rdy("postrst", 3'b110);
    set_in(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
           1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    chk_out("firstacc", 1'b1, 5'd3, 64'h33, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
